// File: rtl/stall_controller.sv
// stall_controller
// Pipeline sequencing controller for the semiMIPS 5-stage core. It drives the
// write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB to handle the following cases:
//   - load-use hazards,
//   - taken-branch flushes,
//   - multi-cycle data-memory accesses (req/ack handshake with a timeout watchdog).
//
// Parameters:
//   MEM_TIMEOUT  maximum MEMWAIT cycles (1..255) before the core halts
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   idexmemrd, idexrt             load in ID/EX and its destination register
//   ifidrs, ifidrt, ifidusesrt    IF/ID source registers, rt-used flag
//   brtaken                       branch/jump resolved taken in ID
//   exmemmemrd, exmemmemwr        load/store in EX/MEM
//   dmemack                       data memory completes the access this cycle
//   dmemreq                       access request to data memory
//   pcwr, ifidwr                  PC / IF/ID write enables
//   ifidflush, idexbubble         IF/ID flush, ID/EX bubble
//   exmemhold, memwbbubble        EX/MEM + ID/EX hold, MEM/WB bubble
//   memerr                        sticky watchdog flag (registered)
//   stallcnt                      stall-cycle counter (registered)
//
// Build option:
//   STALL_CNT_EN  when defined, stallcnt counts clock edges with pcwr=0 and
//                 saturates at all-ones; when undefined it is tied to zero.

module stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idexmemrd,
    input  logic [4:0]  idexrt,
    input  logic [4:0]  ifidrs,
    input  logic [4:0]  ifidrt,
    input  logic        ifidusesrt,
    input  logic        brtaken,
    input  logic        exmemmemrd,
    input  logic        exmemmemwr,
    input  logic        dmemack,
    output logic        dmemreq,
    output logic        pcwr,
    output logic        ifidwr,
    output logic        ifidflush,
    output logic        idexbubble,
    output logic        exmemhold,
    output logic        memwbbubble,
    output logic        memerr,
    output logic [31:0] stallcnt
);

    localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        HALT    = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WCW-1:0]   r_waitcnt;
    logic [WCW-1:0]   w_waitcnt_next;
    logic             r_memerr;
    logic             w_memerr_set;
    logic             w_memacc;
    logic             w_loaduse;

    assign w_memacc  = exmemmemrd | exmemmemwr;
    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_loaduse = idexmemrd && (idexrt != 5'd0) &&
                       ((idexrt == ifidrs) || (ifidusesrt && (idexrt == ifidrt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_waitcnt <= '0;
            r_memerr  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_waitcnt <= w_waitcnt_next;
            if (w_memerr_set)
                r_memerr <= 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_waitcnt_next = r_waitcnt;
        w_memerr_set   = 1'b0;
        dmemreq        = w_memacc && (r_state != HALT);
        pcwr           = 1'b1;
        ifidwr         = 1'b1;
        ifidflush      = 1'b0;
        idexbubble     = 1'b0;
        exmemhold      = 1'b0;
        memwbbubble    = 1'b0;

        case (r_state)
            RUN: begin
                // Memory stall masks load-use and branch; those are
                // re-evaluated once the access is released.
                if (w_memacc && !dmemack) begin
                    pcwr           = 1'b0;
                    ifidwr         = 1'b0;
                    exmemhold      = 1'b1;
                    memwbbubble    = 1'b1;
                    w_state_next   = MEMWAIT;
                    w_waitcnt_next = '0;
                end else if (w_loaduse) begin
                    // Branch is re-resolved after the bubble, so no flush here.
                    pcwr       = 1'b0;
                    ifidwr     = 1'b0;
                    idexbubble = 1'b1;
                end else if (brtaken) begin
                    ifidflush = 1'b1;
                end
            end

            MEMWAIT: begin
                if (!dmemack) begin
                    pcwr           = 1'b0;
                    ifidwr         = 1'b0;
                    exmemhold      = 1'b1;
                    memwbbubble    = 1'b1;
                    w_waitcnt_next = r_waitcnt + WCW'(1);
                    if (r_waitcnt == WCW'(MEM_TIMEOUT - 1)) begin
                        w_state_next = HALT;
                        w_memerr_set = 1'b1;
                    end
                end else begin
                    w_state_next = RUN;
                    if (w_loaduse) begin
                        pcwr       = 1'b0;
                        ifidwr     = 1'b0;
                        idexbubble = 1'b1;
                    end else if (brtaken) begin
                        ifidflush = 1'b1;
                    end
                end
            end

            HALT: begin
                dmemreq     = 1'b0;
                pcwr        = 1'b0;
                ifidwr      = 1'b0;
                exmemhold   = 1'b1;
                memwbbubble = 1'b1;
            end

            default: begin
                // Unused encoding 2'b11 falls back to RUN.
                w_state_next   = RUN;
                w_waitcnt_next = '0;
            end
        endcase
    end

    assign memerr = r_memerr;

`ifdef STALL_CNT_EN
    logic [31:0] r_stallcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stallcnt <= '0;
        else if (!pcwr && (r_stallcnt != '1))
            r_stallcnt <= r_stallcnt + 32'd1;
    end

    assign stallcnt = r_stallcnt;
`else
    assign stallcnt = '0;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// tb_stall_controller
// Directed self-checking bench for stall_controller. Two instances share all
// inputs: u_dut8 (MEM_TIMEOUT=8) and u_dut4 (MEM_TIMEOUT=4).

`timescale 1ns/1ps

module tb_stall_controller;

    logic        clk;
    logic        rst;
    logic        idexmemrd;
    logic [4:0]  idexrt;
    logic [4:0]  ifidrs;
    logic [4:0]  ifidrt;
    logic        ifidusesrt;
    logic        brtaken;
    logic        exmemmemrd;
    logic        exmemmemwr;
    logic        dmemack;

    logic        dmemreq8, pcwr8, ifidwr8, ifidflush8, idexbubble8, exmemhold8, memwbbubble8, memerr8;
    logic [31:0] stallcnt8;
    logic        dmemreq4, pcwr4, ifidwr4, ifidflush4, idexbubble4, exmemhold4, memwbbubble4, memerr4;
    logic [31:0] stallcnt4;

    // {dmemreq, pcwr, ifidwr, ifidflush, idexbubble, exmemhold, memwbbubble}
    logic [6:0]  ctl8;
    logic [6:0]  ctl4;
    assign ctl8 = {dmemreq8, pcwr8, ifidwr8, ifidflush8, idexbubble8, exmemhold8, memwbbubble8};
    assign ctl4 = {dmemreq4, pcwr4, ifidwr4, ifidflush4, idexbubble4, exmemhold4, memwbbubble4};

    localparam logic [6:0] DEF    = 7'b0110000;
    localparam logic [6:0] LU     = 7'b0000100;
    localparam logic [6:0] BR     = 7'b0111000;
    localparam logic [6:0] FRZ    = 7'b1000011;
    localparam logic [6:0] HLT    = 7'b0000011;
    localparam logic [6:0] ACC    = 7'b1110000;
    localparam logic [6:0] ACC_BR = 7'b1111000;

    int unsigned checks = 0;
    int unsigned errors = 0;

    stall_controller #(.MEM_TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .idexmemrd(idexmemrd), .idexrt(idexrt), .ifidrs(ifidrs), .ifidrt(ifidrt),
        .ifidusesrt(ifidusesrt), .brtaken(brtaken),
        .exmemmemrd(exmemmemrd), .exmemmemwr(exmemmemwr), .dmemack(dmemack),
        .dmemreq(dmemreq8), .pcwr(pcwr8), .ifidwr(ifidwr8), .ifidflush(ifidflush8),
        .idexbubble(idexbubble8), .exmemhold(exmemhold8), .memwbbubble(memwbbubble8),
        .memerr(memerr8), .stallcnt(stallcnt8)
    );

    stall_controller #(.MEM_TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .idexmemrd(idexmemrd), .idexrt(idexrt), .ifidrs(ifidrs), .ifidrt(ifidrt),
        .ifidusesrt(ifidusesrt), .brtaken(brtaken),
        .exmemmemrd(exmemmemrd), .exmemmemwr(exmemmemwr), .dmemack(dmemack),
        .dmemreq(dmemreq4), .pcwr(pcwr4), .ifidwr(ifidwr4), .ifidflush(ifidflush4),
        .idexbubble(idexbubble4), .exmemhold(exmemhold4), .memwbbubble(memwbbubble4),
        .memerr(memerr4), .stallcnt(stallcnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sc(input int unsigned n);
`ifdef STALL_CNT_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        idexmemrd  = 1'b0;
        idexrt     = 5'd0;
        ifidrs     = 5'd0;
        ifidrt     = 5'd0;
        ifidusesrt = 1'b0;
        brtaken    = 1'b0;
        exmemmemrd = 1'b0;
        exmemmemwr = 1'b0;
        dmemack    = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        #2;
        chk("rst_ctl", 32'(ctl8), 32'(DEF));
        chk("rst_memerr", 32'(memerr8), 32'd0);
        chk("rst_stallcnt", stallcnt8, 32'd0);
        idexmemrd = 1'b1; idexrt = 5'd5; ifidrs = 5'd5;
        #1;
        chk("rst_follows_run_decode", 32'(ctl8), 32'(LU));
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
        chk("run_idle", 32'(ctl8), 32'(DEF));

        // Load-use on rs: single bubble
        idexmemrd = 1'b1; idexrt = 5'd5; ifidrs = 5'd5;
        #1;
        chk("ldu_rs_8", 32'(ctl8), 32'(LU));
        chk("ldu_rs_4", 32'(ctl4), 32'(LU));
        tick();
        idexmemrd = 1'b0;
        #1;
        chk("ldu_one_cycle", 32'(ctl8), 32'(DEF));
        idexmemrd = 1'b1; idexrt = 5'd0; ifidrs = 5'd0;
        #1;
        chk("ldu_r0_no_stall", 32'(ctl8), 32'(DEF));
        idexrt = 5'd7; ifidrt = 5'd7; ifidrs = 5'd3; ifidusesrt = 1'b0;
        #1;
        chk("ldu_rt_unused", 32'(ctl8), 32'(DEF));
        ifidusesrt = 1'b1;
        #1;
        chk("ldu_rt_used", 32'(ctl8), 32'(LU));
        tick();
        clear_inputs();

        // Zero-wait store
        exmemmemwr = 1'b1; dmemack = 1'b1;
        #1;
        chk("zw_store", 32'(ctl8), 32'(ACC));
        tick();
        clear_inputs();
        #1;
        chk("zw_store_stays_run", 32'(ctl8), 32'(DEF));

        // 3-wait load
        rst = 1'b1; #1; rst = 1'b0;
        exmemmemrd = 1'b1;
        #1;
        chk("mw_enter", 32'(ctl8), 32'(FRZ));
        tick();
        idexmemrd = 1'b1; idexrt = 5'd5; ifidrs = 5'd5; brtaken = 1'b1;
        #1;
        chk("mw1_masks_ldu_br", 32'(ctl8), 32'(FRZ));
        tick();
        #1;
        chk("mw2_frozen", 32'(ctl8), 32'(FRZ));
        tick();
        idexmemrd = 1'b0; dmemack = 1'b1;
        #1;
        chk("mw3_release_br", 32'(ctl8), 32'(ACC_BR));
        chk("mw3_release_br_4", 32'(ctl4), 32'(ACC_BR));
        tick();
        clear_inputs();
        #1;
        chk("mw_back_to_run", 32'(ctl8), 32'(DEF));
        chk("mw_stallcnt8", stallcnt8, sc(3));
        chk("mw_stallcnt4", stallcnt4, sc(3));
        chk("mw_no_memerr4", 32'(memerr4), 32'd0);

        // Load-use beats branch, branch re-resolved after the bubble
        idexmemrd = 1'b1; idexrt = 5'd9; ifidrs = 5'd9; brtaken = 1'b1;
        #1;
        chk("ldu_beats_br", 32'(ctl8), 32'(LU));
        tick();
        idexmemrd = 1'b0;
        #1;
        chk("br_after_bubble", 32'(ctl8), 32'(BR));
        tick();
        clear_inputs();

        // Ack without an access is ignored
        dmemack = 1'b1;
        #1;
        chk("stray_ack", 32'(ctl8), 32'(DEF));
        tick();
        chk("stray_ack_next", 32'(ctl8), 32'(DEF));
        dmemack = 1'b0;

        // Watchdog timeout
        rst = 1'b1; #1; rst = 1'b0;
        exmemmemrd = 1'b1;
        #1;
        chk("to_enter_4", 32'(ctl4), 32'(FRZ));
        for (int i = 0; i < 4; i++) tick();
        chk("to4_last_wait", 32'(ctl4), 32'(FRZ));
        chk("to4_last_wait_memerr", 32'(memerr4), 32'd0);
        tick();
        chk("to4_halt", 32'(ctl4), 32'(HLT));
        chk("to4_memerr", 32'(memerr4), 32'd1);
        chk("to8_still_wait", 32'(ctl8), 32'(FRZ));
        for (int i = 0; i < 3; i++) tick();
        chk("to8_last_wait", 32'(ctl8), 32'(FRZ));
        chk("to8_last_wait_memerr", 32'(memerr8), 32'd0);
        tick();
        chk("to8_halt", 32'(ctl8), 32'(HLT));
        chk("to8_memerr", 32'(memerr8), 32'd1);
        chk("to_stallcnt4", stallcnt4, sc(9));
        dmemack = 1'b1;
        #1;
        chk("halt_ignores_ack", 32'(ctl4), 32'(HLT));
        tick();
        chk("halt_sticky", 32'(ctl4), 32'(HLT));
        chk("halt_memerr_sticky", 32'(memerr4), 32'd1);
        chk("halt_stallcnt8", stallcnt8, sc(10));

        // Asynchronous reset out of HALT, no clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("rst_halt_async_ctl", 32'(ctl4), 32'(ACC));
        chk("rst_halt_async_memerr", 32'(memerr4), 32'd0);
        chk("rst_halt_async_stallcnt", stallcnt4, 32'd0);
        dmemack = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        tick();

        // Asynchronous reset in MEMWAIT restarts the wait count
        #2;
        rst = 1'b1;
        dmemack = 1'b1;
        #1;
        chk("rst_mw_async_run_decode", 32'(ctl4), 32'(ACC));
        dmemack = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mw_reenter", 32'(ctl4), 32'(FRZ));
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mw_waitcnt_cleared", 32'(ctl4), 32'(FRZ));
        tick();
        chk("rst_mw_halt_again", 32'(ctl4), 32'(HLT));
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
